// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulate sequencer: widths and the sequencer state type.
package mac_pkg;
  localparam int ACC_W = 21;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mac_acc_seq_if.sv
// Control, term-stream and result-stream signals between the multiplier side and the sequencer.
interface mac_acc_seq_if;
  import mac_pkg::*;

  logic             start;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  modport master (
    output start, len, abort, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, len, abort, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/mac_acc_seq_add21.sv
// add21: 21-bit adder built from 4-bit lookahead blocks with a lookahead chain between blocks.
module add21 (
  input  logic [20:0] a,
  input  logic [20:0] b,
  output logic [20:0] sum,
  output logic        cout
);

  // Block generate/propagate, inter-block carries, then bit carries seeded from each block carry-in.
  always_comb begin : cla_p
    logic [20:0] g_v;
    logic [20:0] p_v;
    logic [5:0]  bg_v;
    logic [5:0]  bp_v;
    logic [6:0]  bc_v;
    logic [20:0] c_v;
    g_v  = a & b;
    p_v  = a ^ b;
    bg_v = 6'd0;
    bp_v = 6'd0;
    bc_v = 7'd0;
    c_v  = 21'd0;
    for (int i = 0; i < 21; i++) begin
      if (i % 4 == 0) begin
        bg_v[i/4] = g_v[i];
        bp_v[i/4] = p_v[i];
      end else begin
        bg_v[i/4] = g_v[i] | (p_v[i] & bg_v[i/4]);
        bp_v[i/4] = bp_v[i/4] & p_v[i];
      end
    end
    for (int k = 0; k < 6; k++) begin
      bc_v[k+1] = bg_v[k] | (bp_v[k] & bc_v[k]);
    end
    c_v[0] = bc_v[0];
    for (int i = 1; i < 21; i++) begin
      if (i % 4 == 0) begin
        c_v[i] = bc_v[i/4];
      end else begin
        c_v[i] = g_v[i-1] | (p_v[i-1] & c_v[i-1]);
      end
    end
    sum  = p_v ^ c_v;
    cout = bc_v[6];
  end

endmodule

// File: rtl/mac_acc_seq.sv
// mac_acc_seq: accumulates a programmed number of product terms into a wrapping 21-bit sum
// with a sticky carry-out flag, presenting the result over a valid/ready stream.
module mac_acc_seq
  import mac_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mac_acc_seq_if.slave  bus
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic             busy_q, busy_d;
  logic [ACC_W-1:0] add_sum_s;
  logic             add_cout_s;

  add21 u_add21 (
    .a    (acc_q),
    .b    (bus.in_data),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Next state and datapath; abort overrides everything. Outputs are precomputed from the next state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (bus.abort) begin
      state_d = IDLE;
      acc_d   = {ACC_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_d = {ACC_W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
            ovf_d = 1'b0;
            if (bus.len != {CNT_W{1'b0}}) begin
              len_d   = bus.len;
              state_d = ACC;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            acc_d = add_sum_s;
            ovf_d = ovf_q | add_cout_s;
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            // Compare before increment so len_q = 2^CNT_W-1 terminates without cnt wrapping.
            if (cnt_q == len_q - {{(CNT_W-1){1'b0}}, 1'b1}) begin
              state_d = DONE;
            end else begin
              state_d = ACC;
            end
          end else begin
            state_d = ACC;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == ACC) || (state_d == DONE);
    if (state_d == DONE) begin
      out_sum_d = acc_d;
      out_ovf_d = ovf_d;
    end else begin
      out_sum_d = {ACC_W{1'b0}};
      out_ovf_d = 1'b0;
    end
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      len_q       <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= {ACC_W{1'b0}};
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mac_acc_seq.sv
// Self-checking bench for mac_acc_seq: table vectors, hand-written corner sequences and
// randomized runs checked against a plain-arithmetic run model.
module tb_mac_acc_seq;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   hs_cnt;
  logic [20:0] terms_q[$];

  mac_acc_seq_if bus ();

  mac_acc_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so at the falling edge they show what the next edge samples.
  initial hs_cnt = 0;
  always @(negedge clk) begin
    if (rst_n && !bus.abort && bus.in_valid && bus.in_ready) hs_cnt++;
  end

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0][20:0] terms;
    logic [20:0]      exp_sum;
    logic             exp_ovf;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: true unsigned total; carry-out occurred somewhere iff the total reaches 2^21.
  task automatic model(output logic [20:0] s, output logic o);
    longint tot;
    tot = 0;
    foreach (terms_q[i]) tot += longint'(terms_q[i]);
    s = tot[20:0];
    o = (tot >= 64'sd2097152);
  endtask

  task automatic start_run(input logic [7:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send_term(input logic [20:0] d);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && w < 50) begin
      step();
      w++;
    end
    if (!bus.in_ready) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    else step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [20:0] es, input logic eo, input int hold);
    int w;
    w = 0;
    while (!bus.out_valid && w < 50) begin
      step();
      w++;
    end
    check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({name, "_sum"}, {11'd0, bus.out_sum}, {11'd0, es});
    check({name, "_ovf"}, {31'd0, bus.out_ovf}, {31'd0, eo});
    for (int i = 0; i < hold; i++) begin
      step();
      check({name, "_hold_sum"}, {11'd0, bus.out_sum}, {11'd0, es});
      check({name, "_hold_ovf"}, {31'd0, bus.out_ovf}, {31'd0, eo});
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({name, "_drain"}, {30'd0, bus.out_valid, bus.busy}, 32'd0);
  endtask

  task automatic do_run(input int gap_max);
    start_run(8'(terms_q.size()));
    foreach (terms_q[i]) begin
      repeat ($urandom_range(0, gap_max)) step();
      send_term(terms_q[i]);
    end
    check("latency_valid", {31'd0, bus.out_valid}, 32'd1);
  endtask

  initial begin
    vec_t vecs[6];
    logic [20:0] es;
    logic eo;
    int base;
    int w;
    tests = 0;
    fails = 0;

    vecs[0] = '{len: 8'd3, terms: {21'd0, 21'd20, 21'd10, 21'd5}, exp_sum: 21'd35, exp_ovf: 1'b0};
    vecs[1] = '{len: 8'd2, terms: {21'd0, 21'd0, 21'h000002, 21'h1FFFFF}, exp_sum: 21'h000001, exp_ovf: 1'b1};
    vecs[2] = '{len: 8'd1, terms: {21'd0, 21'd0, 21'd0, 21'd7}, exp_sum: 21'd7, exp_ovf: 1'b0};
    vecs[3] = '{len: 8'd4, terms: {21'h100000, 21'h100000, 21'h100000, 21'h100000}, exp_sum: 21'd0, exp_ovf: 1'b1};
    vecs[4] = '{len: 8'd2, terms: {21'd0, 21'd0, 21'h100000, 21'h0FFFFF}, exp_sum: 21'h1FFFFF, exp_ovf: 1'b0};
    vecs[5] = '{len: 8'd0, terms: {21'd0, 21'd0, 21'd0, 21'd0}, exp_sum: 21'd0, exp_ovf: 1'b0};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.len = 8'd0; bus.abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 21'd0; bus.out_ready = 1'b0;
    #22;
    check("reset_outputs", {8'd0, bus.in_ready, bus.out_valid, bus.out_ovf, bus.busy, bus.out_sum}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Table-driven vectors
    foreach (vecs[v]) begin
      terms_q = {};
      for (int j = 0; j < int'(vecs[v].len); j++) terms_q.push_back(vecs[v].terms[j]);
      do_run(2);
      wait_result("table", vecs[v].exp_sum, vecs[v].exp_ovf, 1);
    end

    // Reset in the middle of a run
    start_run(8'd4);
    send_term(21'd11);
    send_term(21'd12);
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {8'd0, bus.in_ready, bus.out_valid, bus.out_ovf, bus.busy, bus.out_sum}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    start_run(8'd1);
    send_term(21'd7);
    wait_result("after_reset", 21'd7, 1'b0, 0);

    // Gapped terms 0/2/1 with exact latency
    start_run(8'd3);
    send_term(21'd5);
    check("gap_not_early", {31'd0, bus.out_valid}, 32'd0);
    repeat (2) step();
    send_term(21'd10);
    step();
    send_term(21'd20);
    check("gap_latency", {31'd0, bus.out_valid}, 32'd1);
    wait_result("gap", 21'd35, 1'b0, 0);

    // Overflow with backpressure
    start_run(8'd2);
    send_term(21'h1FFFFF);
    send_term(21'h000002);
    wait_result("ovf_hold", 21'h000001, 1'b1, 4);

    // Zero-length run
    start_run(8'd0);
    check("len0_valid_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    wait_result("len0", 21'd0, 1'b0, 0);

    // Abort together with a third term; the overflow must not survive
    start_run(8'd4);
    send_term(21'h1FFFFF);
    send_term(21'h1FFFFF);
    bus.in_valid = 1'b1;
    bus.in_data  = 21'd100;
    bus.abort    = 1'b1;
    step();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_idle", {29'd0, bus.in_ready, bus.out_valid, bus.busy}, 32'd0);
    start_run(8'd1);
    send_term(21'd9);
    wait_result("after_abort", 21'd9, 1'b0, 0);

    // Abort in DONE wins over a same-cycle result handshake
    start_run(8'd1);
    send_term(21'd3);
    bus.abort = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    check("abort_done", {29'd0, bus.out_valid, bus.out_ovf, bus.busy}, 32'd0);

    // Maximum length, continuous terms, ignored mid-run start
    start_run(8'd255);
    base = hs_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = 21'd1;
    w = 0;
    while (!bus.out_valid && w < 400) begin
      if (w == 10) begin
        bus.start = 1'b1;
        bus.len   = 8'd3;
      end else begin
        bus.start = 1'b0;
      end
      step();
      w++;
    end
    bus.start = 1'b0;
    check("max_handshakes", hs_cnt - base, 32'd255);
    check("max_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    wait_result("max", 21'd255, 1'b0, 0);

    // Back-to-back: start on the completing cycle is ignored
    start_run(8'd1);
    send_term(21'd4);
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    bus.len = 8'd1;
    step();
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    check("b2b_idle", {30'd0, bus.out_valid, bus.busy}, 32'd0);
    step();
    check("b2b_ignored", {30'd0, bus.in_ready, bus.busy}, 32'd0);
    start_run(8'd1);
    send_term(21'd6);
    wait_result("b2b_next", 21'd6, 1'b0, 0);

    // Randomized runs against the model
    for (int r = 0; r < 25; r++) begin
      terms_q = {};
      for (int j = 0; j < int'($urandom_range(0, 6)); j++) begin
        if ($urandom_range(0, 2) == 0) terms_q.push_back(21'h1FFFFF - 21'($urandom_range(0, 15)));
        else terms_q.push_back(21'($urandom));
      end
      model(es, eo);
      do_run(2);
      wait_result("rand", es, eo, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule
